// File: rtl/bitcell_ctrl_pkg.sv
// Shared types and default geometry for the bitcell array controller.
package bitcell_ctrl_pkg;

  localparam int DEFAULT_WORDS = 8;
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    DONE
  } state_e;

endpackage

// File: rtl/bitcell_arbiter.sv
// Two-requester arbiter producing a one-hot grant (bit 0 = A, bit 1 = B).
// BITCELL_CTRL_RR_EN selects round-robin on ties; otherwise A has fixed priority.
module bitcell_arbiter (
`ifdef BITCELL_CTRL_RR_EN
  input  logic       clk,
  input  logic       rst,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic [1:0] grant
);

`ifdef BITCELL_CTRL_RR_EN
  logic prefer_b;

  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prefer_b ? 2'b10 : 2'b01;
  end

  // The side just granted loses the next tie.
  always_ff @(posedge clk) begin
    if (rst)                       prefer_b <= 1'b0;
    else if (take && grant != '0)  prefer_b <= grant[0];
  end
`else
  assign grant = (req == 2'b11) ? 2'b01 : req;
`endif

endmodule

// File: rtl/bitcell_array_ctrl.sv
// Sequencer for a WORDS x WIDTH bitcell array shared by two requesters.
// Define BITCELL_CTRL_RR_EN for round-robin tie-break; default is fixed A priority.
module bitcell_array_ctrl
  import bitcell_ctrl_pkg::*;
#(
  parameter  int WORDS  = DEFAULT_WORDS,
  parameter  int WIDTH  = DEFAULT_WIDTH,
  localparam int ADDR_W = $clog2(WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_a,
  input  logic              req_b,
  input  logic              we_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [WIDTH-1:0]  wdata_a,
  input  logic [WIDTH-1:0]  wdata_b,
  output logic              gnt_a,
  output logic              gnt_b,
  output logic              done_a,
  output logic              done_b,
  output logic [WIDTH-1:0]  rdata,
  output logic [WORDS-1:0]  cell_sel,
  output logic              cell_rw,
  output logic [WIDTH-1:0]  cell_in,
  input  logic [WIDTH-1:0]  cell_out
);

  state_e            state;
  logic [ADDR_W-1:0] lat_addr;
  logic              owner_b;
  logic [1:0]        grant;

  bitcell_arbiter u_arbiter (
`ifdef BITCELL_CTRL_RR_EN
    .clk   (clk),
    .rst   (rst),
    .take  (state == IDLE),
`endif
    .req   ({req_b, req_a}),
    .grant (grant)
  );

  // cell_rw and cell_in double as the latched we/wdata, so they cannot move
  // while a row is selected.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: datapath registers are reset too because cell_in and rdata
      // have observable reset values.
      state    <= IDLE;
      lat_addr <= '0;
      owner_b  <= 1'b0;
      gnt_a    <= 1'b0;
      gnt_b    <= 1'b0;
      done_a   <= 1'b0;
      done_b   <= 1'b0;
      rdata    <= '0;
      cell_sel <= '0;
      cell_rw  <= 1'b0;
      cell_in  <= '0;
    end else begin
      gnt_a  <= 1'b0;
      gnt_b  <= 1'b0;
      done_a <= 1'b0;
      done_b <= 1'b0;
      case (state)
        IDLE: begin
          if (grant != '0) begin
            state    <= SETUP;
            gnt_a    <= grant[0];
            gnt_b    <= grant[1];
            owner_b  <= grant[1];
            lat_addr <= grant[1] ? addr_b : addr_a;
            cell_rw  <= grant[1] ? we_b : we_a;
            if (grant[1]) cell_in <= we_b ? wdata_b : '0;
            else          cell_in <= we_a ? wdata_a : '0;
          end
        end
        SETUP: begin
          state    <= ACCESS;
          cell_sel <= {{(WORDS-1){1'b0}}, 1'b1} << lat_addr;
        end
        ACCESS: begin
          state    <= DONE;
          cell_sel <= '0;
          done_a   <= !owner_b;
          done_b   <= owner_b;
          if (!cell_rw) rdata <= cell_out;
        end
        DONE: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/bitcell_array_ctrl.md
BITCELL_ARRAY_CTRL -- requirements
Module: bitcell_array_ctrl

Interface
REQ-001 Parameter WORDS, default 8, number of rows in the bitcell array; power of two, ADDR_W = log2(WORDS).
REQ-002 Parameter WIDTH, default 4, bitcells per row.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req_a / req_b  input  1  access request from requester A / B, held until gnt.
REQ-006 we_a / we_b  input  1  1 = write, 0 = read; valid with req.
REQ-007 addr_a / addr_b  input  ADDR_W  row address; valid with req.
REQ-008 wdata_a / wdata_b  input  WIDTH  write data; valid with req.
REQ-009 gnt_a / gnt_b  output  1  one-cycle pulse: request accepted, operands latched.
REQ-010 done_a / done_b  output  1  one-cycle pulse: access complete.
REQ-011 rdata  output  WIDTH  read data; valid in the done cycle of a read, held until next read done.
REQ-012 cell_sel  output  WORDS  one-hot row select to the array; all-zero when idle.
REQ-013 cell_rw  output  1  array r_w: 1 = write, 0 = read.
REQ-014 cell_in  output  WIDTH  write data bus to the array.
REQ-015 cell_out  input  WIDTH  out bus of the selected row.

Function
REQ-016 FSM states IDLE, SETUP, ACCESS, DONE; transitions IDLE->SETUP on any req, SETUP->ACCESS, ACCESS->DONE, DONE->IDLE, all unconditional except IDLE.
REQ-017 In IDLE with a winning req, the next edge enters SETUP, asserts gnt of the winner for that one cycle, and latches we/addr/wdata.
REQ-018 SETUP: cell_sel all-zero, cell_rw = latched we, cell_in = latched wdata (write) or 0 (read).
REQ-019 ACCESS: cell_sel = one-hot(latched addr); cell_rw and cell_in unchanged from SETUP.
REQ-020 A read captures cell_out into rdata on the ACCESS->DONE edge; a write leaves rdata unchanged.
REQ-021 DONE: cell_sel all-zero, cell_rw and cell_in held, done of the owner high for that one cycle.
REQ-022 cell_rw and cell_in never change while any cell_sel bit is high.
REQ-023 Latency: req seen in IDLE at cycle 0 -> gnt in cycle 1, cell_sel in cycle 2, done and rdata in cycle 3, IDLE in cycle 4; a held req is re-granted every 4 cycles.
REQ-024 Requests are ignored outside IDLE; a req dropped before gnt is lost, not queued.
REQ-025 Simultaneous req_a and req_b: arbitration per REQ-029; the loser stays pending and wins the next IDLE when still held.
REQ-026 At most one of gnt_a/gnt_b and at most one of done_a/done_b is high in any cycle.

Reset
REQ-027 rst high at an edge forces IDLE, cell_sel=0, cell_rw=0, cell_in=0, gnt_*=0, done_*=0, rdata=0, and sets the round-robin pointer to A.
REQ-028 rst mid-access aborts: no done pulse is issued and cell_sel is zero from the next cycle.

Configuration
REQ-029 Macro BITCELL_CTRL_RR_EN: when defined, two-way round-robin; on a tie the requester not granted last wins, and the pointer updates on each gnt. When undefined, fixed priority: A always wins ties, with no pointer state.

Structure
REQ-030 Shared package bitcell_ctrl_pkg holds the state enum (IDLE, SETUP, ACCESS, DONE) and the default WORDS/WIDTH constants.
REQ-031 Arbitration is a sub-module bitcell_arbiter (2 requests in, 2 one-hot grants out, round-robin pointer under BITCELL_CTRL_RR_EN).

Verification
REQ-032 Write A: req_a, we_a=1, addr_a=3, wdata_a=4'hA -> gnt_a in cycle 1, cell_sel=8'h08 with cell_rw=1 and cell_in=4'hA in cycle 2 only, done_a in cycle 3.
REQ-033 Read B after REQ-032: req_b, we_b=0, addr_b=3, model returns 4'hA -> rdata=4'hA with done_b in cycle 3, cell_rw=0 throughout.
REQ-034 Tie, both held for 3 grants: with BITCELL_CTRL_RR_EN the grants go A,B,A; without it they go A,A,A.
REQ-035 Assert rst during ACCESS -> no done, cell_sel=0 next cycle, all outputs at reset values, and a new req is granted normally afterwards.
REQ-036 Random traffic checker: never more than one cell_sel bit high, cell_rw/cell_in stable while cell_sel is nonzero, and one done per gnt.
